// File: rtl/ibex_id_wb_ctrl_pkg.sv
// rtl/ibex_id_wb_ctrl_pkg.sv - shared types and constants for the ID/WB controller
//
// Purpose: state encoding, multicycle unit indices and stall-bit offsets
// used by ibex_id_wb_ctrl and its watchdog timer.
package ibex_id_wb_ctrl_pkg;

  typedef enum logic {
    IDLE            = 1'b0,
    WAIT_MULTICYCLE = 1'b1
  } id_wb_state_e;

  // Bit positions in unit_req_i / unit_valid_i
  localparam int unsigned UNIT_LSU  = 0;
  localparam int unsigned UNIT_MULT = 1;
  localparam int unsigned UNIT_DIV  = 2;

  // Stall bits beyond the units, as offsets added to NumUnits
  localparam int unsigned STALL_BRANCH_OFS = 0;
  localparam int unsigned STALL_JUMP_OFS   = 1;

endpackage

// File: rtl/ibex_id_wb_timer.sv
// rtl/ibex_id_wb_timer.sv - per-instruction watchdog counter
//
// Purpose: counts cycles spent waiting on a multicycle instruction.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   clear_i        restart the count from zero (wins over en_i)
//   en_i           advance the count by one
//   expired_o      count has reached all-ones
module ibex_id_wb_timer #(
  parameter int unsigned Width = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign expired_o = &cnt_q;

  // Saturate at all-ones so a missed expiry cannot wrap back to zero
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ibex_id_wb_ctrl.sv
// rtl/ibex_id_wb_ctrl.sv - ID-stage multicycle tracker and writeback controller
//
// Purpose: tracks multicycle units, branches and jumps for the instruction in
// ID, drives stall/retire to the controller and the write enable to the RF.
// Ports:
//   instr_new_i, instr_fetch_err_i      new instruction / must not execute
//   unit_req_i, branch/jump_in_dec_i    decoded instruction class
//   branch_decision_i                   branch taken
//   unit_valid_i, load_err_i            unit completion, LSU error
//   flush_i                             abort the waiting instruction
//   rf_we_dec_i, rf_waddr_i             decoded destination write
//   rf_raddr_a_i, rf_raddr_b_i          source registers for forwarding
//   instr_executing_o, stall_o          to controller
//   branch_set_o, instr_ret_o           taken-branch flag, retire pulse
//   rf_we_o, rf_waddr_o                 to register file
//   fwd_a_o, fwd_b_o                    take operand from WB stage
//   perf_branch_o, timeout_o, busy_o    status
module ibex_id_wb_ctrl
  import ibex_id_wb_ctrl_pkg::*;
#(
  parameter int unsigned NumUnits       = 3,
  parameter int unsigned RegAddrW       = 5,
  parameter int unsigned TimeoutW       = 8,
  parameter bit          WritebackStage = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  instr_new_i,
  input  logic                  instr_fetch_err_i,
  input  logic [NumUnits-1:0]   unit_req_i,
  input  logic                  branch_in_dec_i,
  input  logic                  jump_in_dec_i,
  input  logic                  branch_decision_i,
  input  logic [NumUnits-1:0]   unit_valid_i,
  input  logic                  load_err_i,
  input  logic                  flush_i,
  input  logic                  rf_we_dec_i,
  input  logic [RegAddrW-1:0]   rf_waddr_i,
  input  logic [RegAddrW-1:0]   rf_raddr_a_i,
  input  logic [RegAddrW-1:0]   rf_raddr_b_i,
  output logic                  instr_executing_o,
  output logic [NumUnits+1:0]   stall_o,
  output logic                  branch_set_o,
  output logic                  rf_we_o,
  output logic [RegAddrW-1:0]   rf_waddr_o,
  output logic                  fwd_a_o,
  output logic                  fwd_b_o,
  output logic                  instr_ret_o,
  output logic                  perf_branch_o,
  output logic                  timeout_o,
  output logic                  busy_o
);

  localparam int unsigned NumCls    = NumUnits + 2;
  localparam int unsigned BranchBit = NumUnits + STALL_BRANCH_OFS;
  localparam int unsigned JumpBit   = NumUnits + STALL_JUMP_OFS;

  id_wb_state_e        state_q, state_d;
  logic                done_q, done_d;
  logic                branch_set_q, branch_set_d;
  logic [NumCls-1:0]   act_q, act_d;

  logic [NumCls-1:0]   req_vec, sel, valid_ext, stall;
  logic                found, multicycle, accept, unit_sel, br_sel, jmp_sel;
  logic                enter_wait, in_wait, complete;
  logic                wait_flush, wait_done, wait_to;
  logic                ret, issue, perf_branch, timeout, tmr_clr, tmr_en, tmr_expired;
  logic                issue_we, wb_valid_q, rf_we_raw;
  logic [RegAddrW-1:0] wb_waddr_q, rf_waddr_raw;

  assign req_vec = {jump_in_dec_i, branch_in_dec_i, unit_req_i};

  // Lowest set bit wins: units before branch before jump
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NumCls; i++) begin
      if (req_vec[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  // Branch and jump finish on the ALU's completion strobe
  assign valid_ext  = {unit_valid_i[UNIT_MULT], unit_valid_i[UNIT_MULT], unit_valid_i};

  assign multicycle = |req_vec;
  assign accept     = instr_new_i & ~instr_fetch_err_i;
  assign unit_sel   = |sel[NumUnits-1:0];
  assign br_sel     = sel[BranchBit];
  assign jmp_sel    = sel[JumpBit];
  assign enter_wait = accept & (unit_sel | (br_sel & branch_decision_i) | jmp_sel);

  assign in_wait    = (state_q == WAIT_MULTICYCLE);
  assign complete   = |(act_q & valid_ext);
  assign wait_flush = in_wait & flush_i;
  assign wait_done  = in_wait & ~flush_i & complete;
  assign wait_to    = in_wait & ~flush_i & ~complete & tmr_expired;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      done_q       <= 1'b0;
      branch_set_q <= 1'b0;
      act_q        <= '0;
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      branch_set_q <= branch_set_d;
      act_q        <= act_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    done_d       = done_q;
    branch_set_d = 1'b0;
    act_d        = act_q;
    unique case (state_q)
      IDLE: begin
        if (enter_wait) begin
          state_d      = WAIT_MULTICYCLE;
          done_d       = 1'b0;
          act_d        = sel;
          branch_set_d = br_sel;
        end else if (accept && br_sel) begin
          done_d = 1'b1;
        end
      end
      WAIT_MULTICYCLE: begin
        if (wait_flush || wait_done || wait_to) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall       = '0;
    ret         = 1'b0;
    issue       = 1'b0;
    perf_branch = 1'b0;
    timeout     = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        perf_branch = accept & br_sel;
        if (enter_wait) begin
          stall   = sel;
          tmr_clr = 1'b1;
        end else if (accept) begin
          ret   = 1'b1;
          issue = rf_we_dec_i & ~br_sel;
        end
      end
      WAIT_MULTICYCLE: begin
        tmr_en  = 1'b1;
        timeout = wait_to;
        if (wait_done) begin
          ret   = 1'b1;
          issue = rf_we_dec_i & ~(act_q[UNIT_LSU] & load_err_i);
        end
        if (!(wait_flush || wait_done || wait_to)) begin
          stall = act_q;
        end
      end
      default: ;
    endcase
  end

  assign issue_we = issue & (rf_waddr_i != '0);

  if (TimeoutW > 0) begin : g_timer
    ibex_id_wb_timer #(.Width(TimeoutW)) u_timer (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (tmr_clr),
      .en_i     (tmr_en),
      .expired_o(tmr_expired)
    );
  end else begin : g_no_timer
    assign tmr_expired = 1'b0;
  end

  if (WritebackStage) begin : g_wb
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wb_valid_q <= 1'b0;
        wb_waddr_q <= '0;
      end else begin
        wb_valid_q <= issue_we;
        wb_waddr_q <= issue_we ? rf_waddr_i : '0;
      end
    end
    assign rf_we_raw    = wb_valid_q;
    assign rf_waddr_raw = wb_waddr_q;
  end else begin : g_no_wb
    assign wb_valid_q   = 1'b0;
    assign wb_waddr_q   = '0;
    assign rf_we_raw    = issue_we;
    assign rf_waddr_raw = issue_we ? rf_waddr_i : '0;
  end

  // Combinational outputs are forced low while reset is held
  assign instr_executing_o = rst_ni & (instr_new_i | (multicycle & ~done_q)) & ~instr_fetch_err_i;
  assign stall_o           = rst_ni ? stall : '0;
  assign instr_ret_o       = rst_ni & ret;
  assign perf_branch_o     = rst_ni & perf_branch;
  assign timeout_o         = rst_ni & timeout;
  assign rf_we_o           = rst_ni & rf_we_raw;
  assign rf_waddr_o        = rst_ni ? rf_waddr_raw : '0;
  assign branch_set_o      = branch_set_q;
  assign fwd_a_o           = wb_valid_q & (rf_raddr_a_i == wb_waddr_q) & (wb_waddr_q != '0);
  assign fwd_b_o           = wb_valid_q & (rf_raddr_b_i == wb_waddr_q) & (wb_waddr_q != '0);
  assign busy_o            = in_wait | wb_valid_q;

endmodule

// File: tb/tb_ibex_id_wb_ctrl.sv
// tb/tb_ibex_id_wb_ctrl.sv - scoreboard bench for ibex_id_wb_ctrl
module tb_ibex_id_wb_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       instr_new_i, instr_fetch_err_i;
  logic [2:0] unit_req_i, unit_valid_i;
  logic       branch_in_dec_i, jump_in_dec_i, branch_decision_i;
  logic       load_err_i, flush_i, rf_we_dec_i;
  logic [4:0] rf_waddr_i, rf_raddr_a_i, rf_raddr_b_i;
  logic       instr_executing_o, branch_set_o, rf_we_o, fwd_a_o, fwd_b_o;
  logic       instr_ret_o, perf_branch_o, timeout_o, busy_o;
  logic [4:0] stall_o, rf_waddr_o;
  logic [18:0] outs;

  typedef struct {int cyc; int addr;} wr_t;
  int  ret_q[$];
  int  to_q[$];
  wr_t wr_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  ibex_id_wb_ctrl #(
    .NumUnits(3), .RegAddrW(5), .TimeoutW(3), .WritebackStage(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_new_i(instr_new_i), .instr_fetch_err_i(instr_fetch_err_i),
    .unit_req_i(unit_req_i), .branch_in_dec_i(branch_in_dec_i),
    .jump_in_dec_i(jump_in_dec_i), .branch_decision_i(branch_decision_i),
    .unit_valid_i(unit_valid_i), .load_err_i(load_err_i), .flush_i(flush_i),
    .rf_we_dec_i(rf_we_dec_i), .rf_waddr_i(rf_waddr_i),
    .rf_raddr_a_i(rf_raddr_a_i), .rf_raddr_b_i(rf_raddr_b_i),
    .instr_executing_o(instr_executing_o), .stall_o(stall_o),
    .branch_set_o(branch_set_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .instr_ret_o(instr_ret_o),
    .perf_branch_o(perf_branch_o), .timeout_o(timeout_o), .busy_o(busy_o)
  );

  assign outs = {instr_executing_o, stall_o, branch_set_o, rf_we_o, rf_waddr_o,
                 fwd_a_o, fwd_b_o, instr_ret_o, perf_branch_o, timeout_o, busy_o};

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "bench watchdog expired");
  end

  // Monitor: pops expected retire / write / timeout events by cycle stamp
  always @(negedge clk_i) begin
    if (rst_ni) begin
      while (ret_q.size() > 0 && ret_q[0] < cyc) begin
        checks++; errors++;
        $display("FAIL ret_missed: no retire seen, required at cycle %0d", ret_q[0]);
        void'(ret_q.pop_front());
      end
      while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL wr_missed: no write seen, required x%0d at cycle %0d", wr_q[0].addr, wr_q[0].cyc);
        void'(wr_q.pop_front());
      end
      while (to_q.size() > 0 && to_q[0] < cyc) begin
        checks++; errors++;
        $display("FAIL to_missed: no timeout seen, required at cycle %0d", to_q[0]);
        void'(to_q.pop_front());
      end
      if (instr_ret_o) begin
        checks++;
        if (ret_q.size() == 0 || ret_q[0] != cyc) begin
          errors++;
          $display("FAIL ret_unexpected: retire at cycle %0d, none required", cyc);
        end else void'(ret_q.pop_front());
      end
      if (rf_we_o) begin
        checks++;
        if (wr_q.size() == 0 || wr_q[0].cyc != cyc) begin
          errors++;
          $display("FAIL wr_unexpected: write x%0d at cycle %0d, none required", rf_waddr_o, cyc);
        end else begin
          if (rf_waddr_o != wr_q[0].addr[4:0]) begin
            errors++;
            $display("FAIL wr_addr: got x%0d required x%0d at cycle %0d", rf_waddr_o, wr_q[0].addr, cyc);
          end
          void'(wr_q.pop_front());
        end
      end
      if (timeout_o) begin
        checks++;
        if (to_q.size() == 0 || to_q[0] != cyc) begin
          errors++;
          $display("FAIL to_unexpected: timeout at cycle %0d, none required", cyc);
        end else void'(to_q.pop_front());
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_in();
    instr_new_i = 0; instr_fetch_err_i = 0; unit_req_i = 0; unit_valid_i = 0;
    branch_in_dec_i = 0; jump_in_dec_i = 0; branch_decision_i = 0;
    load_err_i = 0; flush_i = 0; rf_we_dec_i = 0; rf_waddr_i = 0;
    rf_raddr_a_i = 0; rf_raddr_b_i = 0;
  endtask

  task automatic push_wr(input int c, input int a);
    wr_t e;
    e.cyc = c; e.addr = a;
    wr_q.push_back(e);
  endtask

  // Multicycle unit instruction completing after n cycles in WAIT
  task automatic mc_seq(input string tag, input logic [2:0] req, input logic [4:0] exp_stall,
                        input int n, input logic [2:0] valid, input logic lerr,
                        input logic [4:0] waddr, input logic we_exp);
    idle_in();
    instr_new_i = 1; unit_req_i = req; rf_we_dec_i = 1; rf_waddr_i = waddr;
    ret_q.push_back(cyc + n);
    if (we_exp) push_wr(cyc + n + 1, waddr);
    #1 chk({tag, "_stall0"}, stall_o, exp_stall);
    for (int i = 1; i < n; i++) begin
      step(); instr_new_i = 0;
      #1 chk({tag, "_stall_hold"}, stall_o, exp_stall);
    end
    step(); instr_new_i = 0; unit_valid_i = valid; load_err_i = lerr;
    #1 chk({tag, "_stall_done"}, stall_o, 0);
    step(); idle_in();
  endtask

  initial begin
    rst_ni = 0; idle_in(); instr_new_i = 1;
    repeat (2) @(posedge clk_i);
    #2 chk("reset_outs", outs, 0);
    step(); idle_in(); rst_ni = 1;
    step();

    // Single-cycle ADD x5, then a reader of x5
    instr_new_i = 1; rf_we_dec_i = 1; rf_waddr_i = 5;
    ret_q.push_back(cyc); push_wr(cyc + 1, 5);
    #1 chk("add_exec", instr_executing_o, 1);
    chk("add_stall", stall_o, 0);
    step(); idle_in(); instr_new_i = 1; rf_raddr_a_i = 5; rf_raddr_b_i = 3;
    ret_q.push_back(cyc);
    #1 chk("fwd_a", fwd_a_o, 1);
    chk("fwd_b", fwd_b_o, 0);
    chk("wb_busy", busy_o, 1);
    step(); idle_in(); rf_raddr_a_i = 5;
    #1 chk("fwd_a_stale", fwd_a_o, 0);
    step();

    // unit_valid_i ignored in IDLE
    unit_valid_i = 3'b111;
    #1 chk("idle_valid_busy", busy_o, 0);
    step(); idle_in();

    mc_seq("load",     3'b001, 5'b00001, 3, 3'b001, 1'b0, 5'd7, 1'b1);
    mc_seq("load_err", 3'b001, 5'b00001, 2, 3'b001, 1'b1, 5'd7, 1'b0);
    mc_seq("mult_x0",  3'b110, 5'b00010, 1, 3'b010, 1'b0, 5'd0, 1'b0);
    mc_seq("div",      3'b100, 5'b00100, 2, 3'b100, 1'b1, 5'd9, 1'b1);

    // Branch not taken
    instr_new_i = 1; branch_in_dec_i = 1; branch_decision_i = 0;
    ret_q.push_back(cyc);
    #1 chk("bnt_perf", perf_branch_o, 1);
    chk("bnt_stall", stall_o, 0);
    step(); idle_in();
    #1 chk("bnt_bset", branch_set_o, 0);
    chk("bnt_busy", busy_o, 0);
    step();

    // Branch taken
    instr_new_i = 1; branch_in_dec_i = 1; branch_decision_i = 1;
    #1 chk("bt_perf", perf_branch_o, 1);
    step(); instr_new_i = 0;
    ret_q.push_back(cyc + 1);
    #1 chk("bt_bset", branch_set_o, 1);
    chk("bt_busy", busy_o, 1);
    step(); unit_valid_i = 3'b010;
    step(); idle_in();
    #1 chk("bt_bset_clr", branch_set_o, 0);
    step();

    // Jump writing x1
    instr_new_i = 1; jump_in_dec_i = 1; rf_we_dec_i = 1; rf_waddr_i = 1;
    ret_q.push_back(cyc + 1); push_wr(cyc + 2, 1);
    #1 chk("jmp_stall", stall_o, 5'b10000);
    step(); instr_new_i = 0; unit_valid_i = 3'b010;
    step(); idle_in();
    step();

    // Div with no completion: watchdog fires after 7 WAIT cycles
    instr_new_i = 1; unit_req_i = 3'b100; rf_we_dec_i = 1; rf_waddr_i = 9;
    to_q.push_back(cyc + 8);
    for (int i = 1; i <= 7; i++) begin
      step(); instr_new_i = 0;
      #1 chk("to_early", timeout_o, 0);
    end
    step();
    #1 chk("to_stall", stall_o, 0);
    step(); idle_in();
    #1 chk("to_busy", busy_o, 0);
    step();

    // Flush beats a simultaneous completion
    instr_new_i = 1; unit_req_i = 3'b001; rf_we_dec_i = 1; rf_waddr_i = 3;
    step(); instr_new_i = 0; unit_valid_i = 3'b001; flush_i = 1;
    #1 chk("flush_stall", stall_o, 0);
    step(); idle_in();
    #1 chk("flush_busy", busy_o, 0);
    step();

    // Reset asserted mid-WAIT
    instr_new_i = 1; unit_req_i = 3'b001;
    step(); instr_new_i = 0;
    #1 chk("rst_pre_stall", stall_o, 5'b00001);
    rst_ni = 0;
    #1 chk("reset_async", outs, 0);
    idle_in();
    step(); step(); rst_ni = 1;
    step();
    instr_new_i = 1; rf_we_dec_i = 1; rf_waddr_i = 2;
    ret_q.push_back(cyc); push_wr(cyc + 1, 2);
    #1 chk("post_rst_exec", instr_executing_o, 1);
    step(); idle_in();
    step(); step();

    checks++;
    if (ret_q.size() + wr_q.size() + to_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected events never seen, required 0",
               ret_q.size() + wr_q.size() + to_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
